// File: rtl/egg_timer_pkg.sv
// Shared constants and helpers for the egg timer cook-time entry path.
// State encoding, unit widths and the minutes/seconds arithmetic live here.
package egg_timer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EDIT = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  localparam int SECS_PER_MIN = 60;
  localparam int MAX_UNIT_DEF = 59;
  localparam int LOAD_W       = 12;
  localparam int UNIT_W       = 6;

  // m*60 + s using shifts only: (m<<6)-(m<<2); the largest result is 3599.
  function automatic logic [LOAD_W-1:0] total_secs(input logic [UNIT_W-1:0] m,
                                                   input logic [UNIT_W-1:0] s);
    logic [LOAD_W-1:0] m12;
    logic [LOAD_W-1:0] s12;
    m12 = {{(LOAD_W-UNIT_W){1'b0}}, m};
    s12 = {{(LOAD_W-UNIT_W){1'b0}}, s};
    return (m12 << 6) - (m12 << 2) + s12;
  endfunction

  function automatic logic [UNIT_W-1:0] next_unit(input logic [UNIT_W-1:0] v,
                                                  input logic [UNIT_W-1:0] max_v);
    return (v == max_v) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/btn_stepper.sv
// Turns one debounced button level into 1-cycle step pulses.
// With AUTO_REPEAT_EN defined, a held button also repeats after a hold delay.
module btn_stepper #(
  parameter int HOLD_CYCLES   = 2_500_000,
  parameter int REPEAT_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic active,
  output logic step
);

  logic btn_q;
  logic press;

  // btn_q tracks in every state so a button held into EDIT gives no step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_q <= 1'b0;
    else      btn_q <= btn;
  end

  assign press = btn & ~btn_q;

`ifdef AUTO_REPEAT_EN
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic             run;
  logic             repeat_phase;
  logic [CNT_W-1:0] cnt;
  logic             rep;

  // cnt equals the number of cycles since the press edge (or the last repeat).
  assign rep = run & btn &
               (repeat_phase ? (cnt == CNT_W'(REPEAT_CYCLES))
                             : (cnt == CNT_W'(HOLD_CYCLES)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run          <= 1'b0;
      repeat_phase <= 1'b0;
      cnt          <= '0;
    end else if (!active || !btn) begin
      run          <= 1'b0;
      repeat_phase <= 1'b0;
      cnt          <= '0;
    end else if (press) begin
      run          <= 1'b1;
      repeat_phase <= 1'b0;
      cnt          <= CNT_W'(1);
    end else if (rep) begin
      repeat_phase <= 1'b1;
      cnt          <= CNT_W'(1);
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign step = active & (press | rep);
`else
  logic unused_params;
  assign unused_params = HOLD_CYCLES[0] ^ REPEAT_CYCLES[0];
  assign step = active & press;
`endif

endmodule

// File: rtl/cook_time_setter.sv
// Cook-time entry: steps minute/second settings in EDIT and hands the total
// to the countdown timer over a req/ack load. Optional macro: AUTO_REPEAT_EN.
module cook_time_setter
  import egg_timer_pkg::*;
#(
  parameter int HOLD_CYCLES   = 2_500_000,
  parameter int REPEAT_CYCLES = 500_000,
  parameter int MAX_UNIT      = MAX_UNIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              mins,
  input  logic              secs,
  input  logic              clear,
  input  logic              load_ack,
  output logic              load_req,
  output logic [LOAD_W-1:0] load_value,
  output logic [UNIT_W-1:0] mins_val,
  output logic [UNIT_W-1:0] secs_val,
  output logic              editing,
  output logic [1:0]        fsm_state
);

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       in_edit;
  logic       step_m;
  logic       step_s;

  assign in_edit   = (state == ST_EDIT);
  assign fsm_state = state;

  btn_stepper #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_mins_step (
    .clk    (clk),
    .rst    (rst),
    .btn    (mins),
    .active (in_edit),
    .step   (step_m)
  );

  btn_stepper #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_secs_step (
    .clk    (clk),
    .rst    (rst),
    .btn    (secs),
    .active (in_edit),
    .step   (step_s)
  );

  // In LOAD, cfg_en (abort back to EDIT) outranks a simultaneous load_ack.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (cfg_en) state_nx = ST_EDIT;
      ST_EDIT: if (!cfg_en) state_nx = ST_LOAD;
      ST_LOAD: begin
        if (cfg_en)        state_nx = ST_EDIT;
        else if (load_ack) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      editing <= 1'b0;
    end else begin
      state   <= state_nx;
      editing <= (state_nx == ST_EDIT);
    end
  end

  // load_value only changes on the EDIT->LOAD edge, so it is stable under load_req.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_req   <= 1'b0;
      load_value <= '0;
    end else begin
      case (state)
        ST_EDIT: begin
          if (!cfg_en) begin
            load_req   <= 1'b1;
            load_value <= total_secs(mins_val, secs_val);
          end
        end
        ST_LOAD: begin
          if (cfg_en || load_ack) load_req <= 1'b0;
        end
        default: load_req <= 1'b0;
      endcase
    end
  end

  // Seconds wrap on their own; they never carry into minutes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mins_val <= '0;
      secs_val <= '0;
    end else if (in_edit) begin
      if (clear) begin
        mins_val <= '0;
        secs_val <= '0;
      end else begin
        if (step_m) mins_val <= next_unit(mins_val, UNIT_W'(MAX_UNIT));
        if (step_s) secs_val <= next_unit(secs_val, UNIT_W'(MAX_UNIT));
      end
    end
  end

endmodule

// File: tb/tb_cook_time_setter.sv
// Directed bench for cook_time_setter: vector table plus hand sequences for
// load handshake, wrap, abort, held-button entry and auto-repeat.
module tb_cook_time_setter;

  logic        clk;
  logic        rst;
  logic        cfg_en;
  logic        mins;
  logic        secs;
  logic        clear;
  logic        load_ack;
  logic        load_req;
  logic [11:0] load_value;
  logic [5:0]  mins_val;
  logic [5:0]  secs_val;
  logic        editing;
  logic [1:0]  fsm_state;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       cfg_en;
    logic       mins;
    logic       secs;
    logic       clear;
    logic       load_ack;
    logic [5:0] e_mins;
    logic [5:0] e_secs;
    logic       e_req;
    logic [1:0] e_state;
  } vec_t;

  vec_t vecs[9];

  cook_time_setter #(
    .HOLD_CYCLES   (10),
    .REPEAT_CYCLES (4),
    .MAX_UNIT      (59)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_en     (cfg_en),
    .mins       (mins),
    .secs       (secs),
    .clear      (clear),
    .load_ack   (load_ack),
    .load_req   (load_req),
    .load_value (load_value),
    .mins_val   (mins_val),
    .secs_val   (secs_val),
    .editing    (editing),
    .fsm_state  (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic m, input logic s);
    mins = m;
    secs = s;
    cyc();
    mins = 1'b0;
    secs = 1'b0;
    cyc();
  endtask

  initial begin
    //            cfg mn sc clr ack  e_m e_s req st
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 2'd1};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1, 6'd0, 1'b0, 2'd1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1, 6'd0, 1'b0, 2'd1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1, 6'd0, 1'b0, 2'd1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd2, 6'd0, 1'b0, 2'd1};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2, 6'd0, 1'b0, 2'd1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd3, 6'd1, 1'b0, 2'd1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3, 6'd1, 1'b0, 2'd1};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 2'd1};

    rst = 1'b0; cfg_en = 1'b0; mins = 1'b0; secs = 1'b0; clear = 1'b0; load_ack = 1'b0;
    repeat (3) cyc();
    check("rst_state", fsm_state, 2'd0);
    check("rst_mins", mins_val, 0);
    check("rst_secs", secs_val, 0);
    check("rst_req", load_req, 0);
    check("rst_val", load_value, 0);
    check("rst_edit", editing, 0);
    rst = 1'b1;
    cyc();

    for (int i = 0; i < 9; i++) begin
      cfg_en = vecs[i].cfg_en; mins = vecs[i].mins; secs = vecs[i].secs;
      clear = vecs[i].clear; load_ack = vecs[i].load_ack;
      cyc();
      check($sformatf("vec%0d_mins", i), mins_val, vecs[i].e_mins);
      check($sformatf("vec%0d_secs", i), secs_val, vecs[i].e_secs);
      check($sformatf("vec%0d_req", i), load_req, vecs[i].e_req);
      check($sformatf("vec%0d_state", i), fsm_state, vecs[i].e_state);
      check($sformatf("vec%0d_edit", i), editing, vecs[i].e_state == 2'd1);
    end
    mins = 1'b0; secs = 1'b0; clear = 1'b0;
    cyc();

    // Asynchronous reset in the middle of an EDIT session.
    repeat (5) press(1'b1, 1'b0);
    check("pre_rst_mins", mins_val, 5);
    check("pre_rst_req", load_req, 0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_mins", mins_val, 0);
    check("async_rst_state", fsm_state, 2'd0);
    check("async_rst_edit", editing, 0);
    check("async_rst_val", load_value, 0);
    cfg_en = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();

    // 3 min 45 s -> 225 on the load handshake.
    cfg_en = 1'b1;
    cyc();
    repeat (3) press(1'b1, 1'b0);
    repeat (45) press(1'b0, 1'b1);
    cfg_en = 1'b0;
    cyc();
    check("load_req_set", load_req, 1);
    check("load_val_225", load_value, 225);
    check("load_state", fsm_state, 2'd2);
    check("load_edit_off", editing, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      check($sformatf("load_hold%0d_val", i), load_value, 225);
      check($sformatf("load_hold%0d_req", i), load_req, 1);
    end
    load_ack = 1'b1;
    cyc();
    load_ack = 1'b0;
    check("ack_req_clr", load_req, 0);
    check("ack_state_idle", fsm_state, 2'd0);
    check("ack_val_keep", load_value, 225);

    // Settings persist; wrap checks and 59:59.
    cfg_en = 1'b1;
    cyc();
    check("persist_mins", mins_val, 3);
    check("persist_secs", secs_val, 45);
    repeat (14) press(1'b0, 1'b1);
    check("secs_59", secs_val, 59);
    press(1'b0, 1'b1);
    check("secs_wrap", secs_val, 0);
    check("secs_no_carry", mins_val, 3);
    repeat (56) press(1'b1, 1'b0);
    check("mins_59", mins_val, 59);
    repeat (59) press(1'b0, 1'b1);
    load_ack = 1'b1;
    cyc();
    load_ack = 1'b0;
    check("ack_in_edit_ignored", fsm_state, 2'd1);
    cfg_en = 1'b0;
    cyc();
    check("max_val_3599", load_value, 3599);
    check("max_req", load_req, 1);

    // Abort: cfg_en beats a simultaneous load_ack.
    cfg_en = 1'b1;
    load_ack = 1'b1;
    cyc();
    load_ack = 1'b0;
    check("abort_state", fsm_state, 2'd1);
    check("abort_req", load_req, 0);
    check("abort_edit", editing, 1);
    press(1'b1, 1'b0);
    check("mins_wrap", mins_val, 0);
    check("mins_wrap_secs", secs_val, 59);

    // Button held across IDLE->EDIT entry gives no step until re-press.
    cfg_en = 1'b0;
    cyc();
    load_ack = 1'b1;
    cyc();
    load_ack = 1'b0;
    check("held_idle_state", fsm_state, 2'd0);
    secs = 1'b1;
    repeat (2) cyc();
    cfg_en = 1'b1;
    repeat (3) cyc();
    check("held_entry_state", fsm_state, 2'd1);
    check("held_entry_nostep", secs_val, 59);
    secs = 1'b0;
    cyc();
    press(1'b0, 1'b1);
    check("repress_step", secs_val, 0);

    // Hold secs for 30 cycles.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    check("clear_mins", mins_val, 0);
    check("clear_secs", secs_val, 0);
    secs = 1'b1;
    repeat (30) cyc();
    secs = 1'b0;
    cyc();
`ifdef AUTO_REPEAT_EN
    check("hold30_secs", secs_val, 6);
`else
    check("hold30_secs", secs_val, 1);
`endif
    check("hold30_mins", mins_val, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
